// File: rtl/nibble_add_pkg.sv
// Shared definitions for the nibble-serial adder.
//   state_t : controller states (IDLE, RUN, DONE)
//   NIB_W   : width of one adder slice in bits
package nibble_add_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit ripple-carry adder slice with enable.
// Ports:
//   en  : slice enable; when low, s and co are forced to 0
//   a   : addend nibble
//   b   : addend nibble
//   cin : carry into bit 0
//   s   : sum nibble
//   co  : carry out of bit 3
module nibble_add_slice
    import nibble_add_pkg::*;
(
    input  logic             en,
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             co
);

    // Carry chain; gating the incoming carry and every sum bit with en
    // keeps all outputs at 0 while the slice is idle.
    logic [NIB_W:0] c;

    assign c[0] = cin & en;

    for (genvar gi = 0; gi < NIB_W; gi++) begin : g_bit
        assign s[gi]   = en & (a[gi] ^ b[gi] ^ c[gi]);
        assign c[gi+1] = en & ((a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]));
    end

    assign co = c[NIB_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Multi-cycle W-bit adder that reuses one 4-bit slice, one nibble per
// cycle, LSB first, with the carry chained through a register.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start      : request strobe, accepted only while ready
//   a, b, cin  : operands and carry-in, captured on the accepting edge
//   ready      : high in IDLE
//   busy       : high in RUN
//   done       : one-cycle pulse when the result is valid
//   sum        : W-bit result register
//   cout       : carry out of the most significant nibble
//   ovf        : signed overflow of the W-bit addition
module nibble_serial_add_ctrl
    import nibble_add_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [NIB_W*NIBBLES-1:0] a,
    input  logic [NIB_W*NIBBLES-1:0] b,
    input  logic                     cin,
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic [NIB_W*NIBBLES-1:0] sum,
    output logic                     cout,
    output logic                     ovf
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg;
    logic [W-1:0]     a_reg, b_reg, sum_reg;
    logic             carry_reg, cout_reg, ovf_reg;

    logic             slice_en;
    logic [NIB_W-1:0] slice_a, slice_b, slice_s;
    logic             slice_co;
    logic             ovf_next;

    // Nibble views of the latched operands so the slice input is a plain
    // array select on idx.
    logic [NIB_W-1:0] a_nib [NIBBLES];
    logic [NIB_W-1:0] b_nib [NIBBLES];

    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        assign a_nib[gi] = a_reg[gi*NIB_W +: NIB_W];
        assign b_nib[gi] = b_reg[gi*NIB_W +: NIB_W];
    end

    assign slice_a = a_nib[idx_reg];
    assign slice_b = b_nib[idx_reg];

    nibble_add_slice u_slice (
        .en  (slice_en),
        .a   (slice_a),
        .b   (slice_b),
        .cin (carry_reg),
        .s   (slice_s),
        .co  (slice_co)
    );

    // On the last RUN edge the slice sum MSB becomes sum[W-1], so overflow
    // is judged from it directly rather than from the not-yet-written register.
    assign ovf_next = (a_reg[W-1] == b_reg[W-1]) && (slice_s[NIB_W-1] != a_reg[W-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        slice_en   = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                slice_en = 1'b1;
                if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            idx_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        sum_reg   <= '0;
                        cout_reg  <= 1'b0;
                        ovf_reg   <= 1'b0;
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    sum_reg[int'(idx_reg)*NIB_W +: NIB_W] <= slice_s;
                    carry_reg <= slice_co;
                    if (idx_reg == LAST_IDX) begin
                        cout_reg <= slice_co;
                        ovf_reg  <= ovf_next;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule
